int_exe_cluster: RTL

//  Parametrised integer execution cluster between integer dispatch and the ROB writeback ports.

---
 rtl/int_exe_cluster.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/int_exe_cluster.sv
// rtl/int_exe_cluster.sv - integer execution cluster: in-order issue buffer feeding fixed-latency ALU/branch pipes
// Writeback, oldest-branch and oldest-exception reports leave through a LAT-deep register pipe.
module int_exe_cluster #(
   parameter int DISP_WID = 4,
   parameter int NUM_PIPE = 2,
   parameter int DEPTH    = 16,
   parameter int LAT      = 1,
   parameter int XLEN     = 64,
   parameter int ROBIDX_W = 7,
   parameter int OP_W     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   output logic                         o_stall,
   input  logic [DISP_WID-1:0]          i_disp_vld,
   input  logic [DISP_WID*ROBIDX_W-1:0] i_disp_robIdx,
   input  logic [DISP_WID*OP_W-1:0]     i_disp_op,
   input  logic [DISP_WID*XLEN-1:0]     i_disp_src1,
   input  logic [DISP_WID*XLEN-1:0]     i_disp_src2,
   input  logic [DISP_WID-1:0]          i_disp_bpred,
   output logic [NUM_PIPE-1:0]          o_wb_vld,
   output logic [NUM_PIPE*ROBIDX_W-1:0] o_wb_robIdx,
   output logic [NUM_PIPE*XLEN-1:0]     o_wb_result,
   output logic                         o_branchwb_vld,
   output logic [ROBIDX_W-1:0]          o_branchwb_robIdx,
   output logic                         o_branchwb_taken,
   output logic                         o_branchwb_mispred,
   output logic                         o_exceptwb_vld,
   output logic [ROBIDX_W-1:0]          o_exceptwb_robIdx
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = ROBIDX_W - 1;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(8);

   typedef struct packed {
      logic [ROBIDX_W-1:0] rob;
      logic [OP_W-1:0]     op;
      logic [XLEN-1:0]     src1;
      logic [XLEN-1:0]     src2;
      logic                bpred;
   } uop_t;

   typedef struct packed {
      logic [NUM_PIPE-1:0]          wb_vld;
      logic [NUM_PIPE*ROBIDX_W-1:0] wb_rob;
      logic [NUM_PIPE*XLEN-1:0]     wb_res;
      logic                         br_vld;
      logic [ROBIDX_W-1:0]          br_rob;
      logic                         br_taken;
      logic                         br_mispred;
      logic                         ex_vld;
      logic [ROBIDX_W-1:0]          ex_rob;
   } out_t;

   uop_t              buf_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  enq_cnt, deq_cnt;
   logic [DISP_WID-1:0] lane_we;
   logic [PTR_W-1:0]  lane_slot [DISP_WID];
   out_t              stg_q [LAT];
   out_t              stg_d;

   // Age across the ROB wrap: equal flags compare indices directly, differing flags invert the sense.
   function automatic logic older(input logic [ROBIDX_W-1:0] a, input logic [ROBIDX_W-1:0] b);
      if (a[IDX_W] == b[IDX_W]) older = (a[IDX_W-1:0] < b[IDX_W-1:0]);
      else                      older = (a[IDX_W-1:0] > b[IDX_W-1:0]);
   endfunction

   assign o_stall = (count_q > CNT_W'(DEPTH - DISP_WID));

   always_comb begin
      enq_cnt = '0;
      for (int l = 0; l < DISP_WID; l++) begin
         lane_we[l]   = i_disp_vld[l] & ~o_stall & ~i_flush;
         lane_slot[l] = tail_q + PTR_W'(enq_cnt);
         if (lane_we[l]) enq_cnt = enq_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < DISP_WID; l++) begin
         if (lane_we[l]) begin
            buf_q[lane_slot[l]] <= '{rob:   i_disp_robIdx[l*ROBIDX_W +: ROBIDX_W],
                                     op:    i_disp_op[l*OP_W +: OP_W],
                                     src1:  i_disp_src1[l*XLEN +: XLEN],
                                     src2:  i_disp_src2[l*XLEN +: XLEN],
                                     bpred: i_disp_bpred[l]};
         end
      end
   end

   always_comb begin
      deq_cnt = (count_q < CNT_W'(NUM_PIPE)) ? count_q : CNT_W'(NUM_PIPE);
      if (i_flush) deq_cnt = '0;
      head_d  = i_flush ? '0 : head_q + PTR_W'(deq_cnt);
      tail_d  = i_flush ? '0 : tail_q + PTR_W'(enq_cnt);
      count_d = i_flush ? '0 : count_q + enq_cnt - deq_cnt;
   end

   always_comb begin : p_issue
      uop_t            u;
      logic [XLEN-1:0] res;
      logic            taken, mispred, is_br, illegal;
      stg_d   = '0;
      u       = '0;
      res     = '0;
      taken   = 1'b0;
      mispred = 1'b0;
      is_br   = 1'b0;
      illegal = 1'b0;
      for (int k = 0; k < NUM_PIPE; k++) begin
         u       = buf_q[head_q + PTR_W'(k)];
         res     = '0;
         taken   = 1'b0;
         is_br   = 1'b0;
         illegal = 1'b0;
         case (u.op)
            OP_ADD:  res = u.src1 + u.src2;
            OP_SUB:  res = u.src1 - u.src2;
            OP_AND:  res = u.src1 & u.src2;
            OP_OR:   res = u.src1 | u.src2;
            OP_XOR:  res = u.src1 ^ u.src2;
            OP_SLT:  res = XLEN'($signed(u.src1) < $signed(u.src2));
            OP_SLTU: res = XLEN'(u.src1 < u.src2);
            OP_BEQ:  begin is_br = 1'b1; taken = (u.src1 == u.src2); end
            OP_BNE:  begin is_br = 1'b1; taken = (u.src1 != u.src2); end
            default: illegal = 1'b1;
         endcase
         mispred = is_br & (taken ^ u.bpred);
         if (CNT_W'(k) < deq_cnt) begin
            stg_d.wb_vld[k]                       = 1'b1;
            stg_d.wb_rob[k*ROBIDX_W +: ROBIDX_W]  = u.rob;
            stg_d.wb_res[k*XLEN +: XLEN]          = res;
            if ((taken | mispred) && (!stg_d.br_vld || older(u.rob, stg_d.br_rob))) begin
               stg_d.br_vld     = 1'b1;
               stg_d.br_rob     = u.rob;
               stg_d.br_taken   = taken;
               stg_d.br_mispred = mispred;
            end
            if (illegal && (!stg_d.ex_vld || older(u.rob, stg_d.ex_rob))) begin
               stg_d.ex_vld = 1'b1;
               stg_d.ex_rob = u.rob;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int s = 0; s < LAT; s++) stg_q[s] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (i_flush) begin
            for (int s = 0; s < LAT; s++) stg_q[s] <= '0;
         end else begin
            stg_q[0] <= stg_d;
            for (int s = 1; s < LAT; s++) stg_q[s] <= stg_q[s-1];
         end
      end
   end

   assign o_wb_vld           = stg_q[LAT-1].wb_vld;
   assign o_wb_robIdx        = stg_q[LAT-1].wb_rob;
   assign o_wb_result        = stg_q[LAT-1].wb_res;
   assign o_branchwb_vld     = stg_q[LAT-1].br_vld;
   assign o_branchwb_robIdx  = stg_q[LAT-1].br_rob;
   assign o_branchwb_taken   = stg_q[LAT-1].br_taken;
   assign o_branchwb_mispred = stg_q[LAT-1].br_mispred;
   assign o_exceptwb_vld     = stg_q[LAT-1].ex_vld;
   assign o_exceptwb_robIdx  = stg_q[LAT-1].ex_rob;
endmodule
